// File: rtl/circle_pkg.sv
// Shared definitions for the Circle block and its downstream collector:
// default word width/depth, collector state encoding and derived port widths.
package circle_pkg;

  localparam int unsigned CIRCLE_W     = 6;
  localparam int unsigned CIRCLE_DEPTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_REPORT  = 2'd2,
    ST_REPLAY  = 2'd3
  } circle_state_e;

  // Sum of `depth` words of `w` bits never overflows at this width.
  function automatic int unsigned sum_width(input int unsigned w, input int unsigned depth);
    return w + $clog2(depth);
  endfunction

  function automatic int unsigned count_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/circle_stat_acc.sv
// Running sum/max/min/count accumulator for one burst of words.
// init loads the first word, upd folds in another word, otherwise it holds.
module circle_stat_acc
  import circle_pkg::*;
#(
  parameter int unsigned W     = CIRCLE_W,
  parameter int unsigned DEPTH = CIRCLE_DEPTH,
  parameter int unsigned SUM_W = sum_width(W, DEPTH),
  parameter int unsigned CNT_W = count_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             init,
  input  logic             upd,
  input  logic [W-1:0]     word,
  output logic [SUM_W-1:0] sum,
  output logic [W-1:0]     max,
  output logic [W-1:0]     min,
  output logic [CNT_W-1:0] count
);

  logic [SUM_W-1:0] sum_q, sum_d;
  logic [W-1:0]     max_q, max_d;
  logic [W-1:0]     min_q, min_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    sum_d = sum_q;
    max_d = max_q;
    min_d = min_q;
    cnt_d = cnt_q;
    if (init) begin
      sum_d = SUM_W'(word);
      max_d = word;
      min_d = word;
      cnt_d = CNT_W'(1);
    end else if (upd) begin
      sum_d = sum_q + SUM_W'(word);
      if (word > max_q) max_d = word;
      if (word < min_q) min_d = word;
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q <= '0;
      max_q <= '0;
      min_q <= '0;
      cnt_q <= '0;
    end else begin
      sum_q <= sum_d;
      max_q <= max_d;
      min_q <= min_d;
      cnt_q <= cnt_d;
    end
  end

  assign sum   = sum_q;
  assign max   = max_q;
  assign min   = min_q;
  assign count = cnt_q;

endmodule

// File: rtl/circle_out_collector.sv
// Collects one burst of Circle results and reports sum/max/min/count on a
// valid/ready port. Define CIRCLE_COLLECT_REPLAY_EN to replay the burst afterwards.
module circle_out_collector
  import circle_pkg::*;
#(
  parameter int unsigned DEPTH = CIRCLE_DEPTH,
  parameter int unsigned W     = CIRCLE_W,
  localparam int unsigned SUM_W = sum_width(W, DEPTH),
  localparam int unsigned CNT_W = count_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             out_valid,
  input  logic [W-1:0]     out,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [SUM_W-1:0] res_sum,
  output logic [W-1:0]     res_max,
  output logic [W-1:0]     res_min,
  output logic [CNT_W-1:0] res_count,
  output logic             err_overflow,
  output logic             err_drop
`ifdef CIRCLE_COLLECT_REPLAY_EN
  ,
  output logic             rep_valid,
  output logic [W-1:0]     rep_data
`endif
);

  circle_state_e state_q, state_d;
  logic          res_valid_q, res_valid_d;
  logic          err_ov_q, err_ov_d;
  logic          err_drop_q, err_drop_d;
  logic          acc_init, acc_upd;

`ifdef CIRCLE_COLLECT_REPLAY_EN
  localparam int unsigned PTR_W = $clog2(DEPTH);
  logic [W-1:0]     buf_q [DEPTH];
  logic [W-1:0]     buf_d [DEPTH];
  logic [CNT_W-1:0] rd_q, rd_d;
  logic             rep_valid_q, rep_valid_d;
  logic [W-1:0]     rep_data_q, rep_data_d;
`endif

  circle_stat_acc #(
    .W    (W),
    .DEPTH(DEPTH),
    .SUM_W(SUM_W),
    .CNT_W(CNT_W)
  ) u_acc (
    .clk  (clk),
    .rst  (rst),
    .init (acc_init),
    .upd  (acc_upd),
    .word (out),
    .sum  (res_sum),
    .max  (res_max),
    .min  (res_min),
    .count(res_count)
  );

  always_comb begin
    state_d     = state_q;
    res_valid_d = res_valid_q;
    err_ov_d    = err_ov_q;
    err_drop_d  = err_drop_q;
    acc_init    = 1'b0;
    acc_upd     = 1'b0;
`ifdef CIRCLE_COLLECT_REPLAY_EN
    buf_d       = buf_q;
    rd_d        = rd_q;
    rep_valid_d = 1'b0;
    rep_data_d  = rep_data_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (out_valid) begin
          acc_init = 1'b1;
          err_ov_d = 1'b0;
          state_d  = ST_COLLECT;
`ifdef CIRCLE_COLLECT_REPLAY_EN
          buf_d[0] = out;
`endif
        end
      end
      ST_COLLECT: begin
        if (out_valid) begin
          if (res_count < CNT_W'(DEPTH)) begin
            acc_upd = 1'b1;
`ifdef CIRCLE_COLLECT_REPLAY_EN
            buf_d[res_count[PTR_W-1:0]] = out;
`endif
          end else begin
            err_ov_d = 1'b1;
          end
        end else begin
          state_d     = ST_REPORT;
          res_valid_d = 1'b1;
        end
      end
      ST_REPORT: begin
        // No backpressure upstream: a word here can only be flagged.
        if (out_valid) err_drop_d = 1'b1;
        if (res_ready) begin
          res_valid_d = 1'b0;
`ifdef CIRCLE_COLLECT_REPLAY_EN
          rep_valid_d = 1'b1;
          rep_data_d  = buf_q[0];
          rd_d        = CNT_W'(1);
          state_d     = (res_count == CNT_W'(1)) ? ST_IDLE : ST_REPLAY;
`else
          state_d     = ST_IDLE;
`endif
        end
      end
`ifdef CIRCLE_COLLECT_REPLAY_EN
      ST_REPLAY: begin
        if (out_valid) err_drop_d = 1'b1;
        rep_valid_d = 1'b1;
        rep_data_d  = buf_q[rd_q[PTR_W-1:0]];
        rd_d        = rd_q + CNT_W'(1);
        if (rd_q == res_count - CNT_W'(1)) state_d = ST_IDLE;
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      res_valid_q <= 1'b0;
      err_ov_q    <= 1'b0;
      err_drop_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      res_valid_q <= res_valid_d;
      err_ov_q    <= err_ov_d;
      err_drop_q  <= err_drop_d;
    end
  end

  assign res_valid    = res_valid_q;
  assign err_overflow = err_ov_q;
  assign err_drop     = err_drop_q;

`ifdef CIRCLE_COLLECT_REPLAY_EN
  // Burst storage is data-only; validity is tracked by the count.
  always_ff @(posedge clk) begin
    buf_q <= buf_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q        <= '0;
      rep_valid_q <= 1'b0;
      rep_data_q  <= '0;
    end else begin
      rd_q        <= rd_d;
      rep_valid_q <= rep_valid_d;
      rep_data_q  <= rep_data_d;
    end
  end

  assign rep_valid = rep_valid_q;
  assign rep_data  = rep_data_q;
`endif

endmodule
